cycle_sequencer: RTL
====================

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, the memory wait-state limit in cycles (1..15).
REQ-002 SHALL have port clock  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port run_en  in  1  1 = free-running execution; 0 = single-step mode.
REQ-005 SHALL have port step_req  in  1  single-cycle pulse requesting one instruction in step mode.
REQ-006 SHALL have port resume  in  1  single-cycle pulse leaving HALT.
REQ-007 SHALL have port mem_access  in  1  decoded RAM chip-select of the current instruction.
REQ-008 SHALL have port mem_ready  in  1  RAM completion strobe.
REQ-009 SHALL have port halt_instr  in  1  current instruction is the halt opcode.
REQ-010 SHALL have port phase  out  1  0 = fetch, 1 = execute (including memory wait).
REQ-011 SHALL have port fetch_en  out  1  load enable for the instruction/operand registers.
REQ-012 SHALL have port exec_en  out  1  qualifies decoded register loads and PC load/increment.
REQ-013 SHALL have port mem_req  out  1  RAM request, held until mem_ready or timeout.
REQ-014 SHALL have port halted  out  1  sequencer is in HALT.
REQ-015 SHALL have port bus_error  out  1  sticky memory-timeout flag.
REQ-016 SHALL have port instr_count  out  8  count of completed instructions.

Function
REQ-017 SHALL implement states FETCH, EXEC, MEM_WAIT, HALT; all outputs SHALL be registered or decoded from state only, except mem_req as stated below.
REQ-018 In FETCH: if run_en=1, or run_en=0 with step_req=1, fetch_en=1 for one cycle, then EXEC; otherwise remain in FETCH with fetch_en=0.
REQ-019 In EXEC with halt_instr=1: exec_en=0, next state HALT; halt_instr SHALL take priority over mem_access.
REQ-020 In EXEC with mem_access=0: exec_en=1 for one cycle, instr_count increments, next state FETCH.
REQ-021 In EXEC with mem_access=1: mem_req=1 combinationally; if mem_ready=1 in the same cycle, exec_en=1 and instr_count increments, next state FETCH; otherwise next state MEM_WAIT with the wait counter cleared.
REQ-022 In MEM_WAIT: mem_req=1; wait counter increments each cycle; on mem_ready=1, exec_en=1 for that cycle, instr_count increments, next state FETCH.
REQ-023 In MEM_WAIT: if the wait counter reaches MAX_WAIT without mem_ready, exec_en stays 0, bus_error sets, next state HALT; mem_ready arriving in the same cycle SHALL win over timeout.
REQ-024 In HALT: halted=1, phase=1, no enables asserted; resume=1 moves to FETCH; step_req in HALT SHALL be ignored.
REQ-025 bus_error SHALL clear only on reset or when resume leaves HALT.
REQ-026 instr_count SHALL wrap 255 -> 0 without flag.
REQ-027 phase SHALL be 0 only in FETCH; fetch_en and exec_en SHALL never both be 1.
REQ-028 step_req outside FETCH SHALL be discarded (no latching); run_en changes take effect at the next FETCH decision.

Reset
REQ-029 While reset=0: state FETCH, phase=0, fetch_en=0, exec_en=0, mem_req=0, halted=0, bus_error=0, instr_count=0, wait counter=0.
REQ-030 Reset asserted mid-MEM_WAIT SHALL drop mem_req immediately (asynchronously); first fetch occurs on the first edge after release with run_en=1.

Structure
REQ-031 State encoding (2-bit enum) and the MAX_WAIT default SHALL live in the shared processor package.
REQ-032 The wait-state timer SHALL be a sub-module named wait_timer (clear, enable, 4-bit count, expired output).

Verification
REQ-033 run_en=1, mem_access=0, 4 instructions -> phase toggles 0,1,0,1...; instr_count=4 after 8 cycles.
REQ-034 mem_access=1, mem_ready after 3 wait cycles -> mem_req high 4 cycles; exec_en single pulse on the ready cycle; instr_count +1.
REQ-035 mem_access=1, mem_ready never, MAX_WAIT=15 -> HALT after 15 MEM_WAIT cycles; bus_error=1, halted=1; resume -> FETCH, bus_error=0.
REQ-036 run_en=0, step_req pulsed twice 10 cycles apart -> exactly 2 instructions complete; idle in FETCH between.
REQ-037 halt_instr=1 with mem_access=1 -> HALT, mem_req never asserted; step_req in HALT ignored; resume resumes fetching.
REQ-038 instr_count preset via 255 completions, then one more -> 0; reset pulse mid-MEM_WAIT -> all outputs at reset values at once.

Source files
------------

// File: rtl/cycle_sequencer_pkg.sv
// Shared processor package: sequencer state encoding and default limits.
package cycle_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam int MAX_WAIT_DEFAULT = 15;
  localparam int COUNT_W          = 8;

endpackage

// File: rtl/cycle_sequencer_if.sv
// Control/status bundle between the cycle sequencer and the datapath around it.
interface cycle_sequencer_if;
  import cycle_sequencer_pkg::*;

  logic               run_en;
  logic               step_req;
  logic               resume;
  logic               mem_access;
  logic               mem_ready;
  logic               halt_instr;
  logic               phase;
  logic               fetch_en;
  logic               exec_en;
  logic               mem_req;
  logic               halted;
  logic               bus_error;
  logic [COUNT_W-1:0] instr_count;

  // master: the sequencer itself; slave: the datapath/memory side driving it
  modport master (
    input  run_en, step_req, resume, mem_access, mem_ready, halt_instr,
    output phase, fetch_en, exec_en, mem_req, halted, bus_error, instr_count
  );

  modport slave (
    output run_en, step_req, resume, mem_access, mem_ready, halt_instr,
    input  phase, fetch_en, exec_en, mem_req, halted, bus_error, instr_count
  );

endinterface

// File: rtl/cycle_sequencer_wait_timer.sv
// Memory wait-state timer: counts MEM_WAIT cycles, flags the cycle on which the limit is reached.
module wait_timer
  import cycle_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       en_i,
  output logic [3:0] count_o,
  output logic       expired_o
);

  // The count reaches MAX_WAIT at the end of the cycle in which it equals MAX_WAIT-1.
  localparam logic [3:0] LAST = 4'(MAX_WAIT - 1);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 4'd0;
    end else if (en_i) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/cycle_sequencer.sv
// Fetch/execute cycle sequencer with memory wait states, timeout-to-halt and single-step.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  cycle_sequencer_if.master bus
);

  state_t             state_q, state_d;
  logic               bus_error_q, bus_error_d;
  logic [COUNT_W-1:0] instr_count_q, instr_count_d;
  logic               fetch_en, exec_en, mem_req;
  logic               wait_en, wait_clear, wait_expired;
  logic [3:0]         wait_cnt;
  logic               unused_wait_cnt;

  assign wait_en         = (state_q == MEM_WAIT);
  assign wait_clear      = !wait_en;
  assign unused_wait_cnt = ^wait_cnt;

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk_i     (clock),
    .rst_ni    (reset),
    .clear_i   (wait_clear),
    .en_i      (wait_en),
    .count_o   (wait_cnt),
    .expired_o (wait_expired)
  );

  always_comb begin
    state_d     = state_q;
    bus_error_d = bus_error_q;
    fetch_en    = 1'b0;
    exec_en     = 1'b0;
    mem_req     = 1'b0;
    unique case (state_q)
      FETCH: begin
        // Gated by reset so no load enable escapes while the sequencer is held.
        if (reset && (bus.run_en || bus.step_req)) begin
          fetch_en = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (bus.halt_instr) begin
          state_d = HALT;
        end else if (!bus.mem_access) begin
          exec_en = 1'b1;
          state_d = FETCH;
        end else begin
          mem_req = 1'b1;
          if (bus.mem_ready) begin
            exec_en = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          exec_en = 1'b1;
          state_d = FETCH;
        end else if (wait_expired) begin
          bus_error_d = 1'b1;
          state_d     = HALT;
        end
      end
      HALT: begin
        if (bus.resume) begin
          bus_error_d = 1'b0;
          state_d     = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign instr_count_d = instr_count_q + COUNT_W'(exec_en);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH;
      bus_error_q   <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      bus_error_q   <= bus_error_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.phase       = (state_q != FETCH);
  assign bus.halted      = (state_q == HALT);
  assign bus.fetch_en    = fetch_en;
  assign bus.exec_en     = exec_en;
  assign bus.mem_req     = mem_req;
  assign bus.bus_error   = bus_error_q;
  assign bus.instr_count = instr_count_q;

endmodule
